store_merger: RTL and testbench

Narrowing counterpart to the immediate/load extension path: takes a 32-bit register value plus an access size and byte address, and writes only the addressed byte or halfword into word-addressed data memory. Sits between the memory stage and the data-memory port. Sub-word stores are done as read-modify-write; word stores are written directly. Misaligned accesses are flagged and no memory access is made.

---
 rtl/store_merger.sv | 74 +++++++
 tb/tb_store_merger.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/store_merger.sv
// store_merger: narrows a register value into a byte/halfword/word store via read-modify-write
module store_merger (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        misaligned,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    input  logic [31:0] mem_load,
    input  logic        mem_wait
);
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state_q, state_d;
    logic half_q, half_d, mis_q, mis_d, req_mis;
    word_t addr_q, addr_d, buf_q, buf_d, lane_mask, lane_data;
    logic [15:0] wdata_q, wdata_d;
    always_comb begin
        req_mis = size == 2'b01 ? addr[0] : (size[1] && addr[1:0] != 2'b00);
        lane_mask = half_q ? (addr_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000) : 32'hFF00_0000 >> {addr_q[1:0], 3'b000};
        lane_data = half_q ? {2{wdata_q}} : {4{wdata_q[7:0]}};
        state_d = state_q;
        half_d = half_q;
        mis_d = mis_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        buf_d = buf_q;
        case (state_q)
            IDLE: if (req) begin
                half_d = size[0];
                mis_d = req_mis;
                addr_d = addr;
                wdata_d = wdata[15:0];
                buf_d = size[1] && !req_mis ? wdata : buf_q;
                state_d = req_mis ? DONE : size[1] ? WRITE : READ;
            end
            READ: if (!mem_wait) begin
                buf_d = (mem_load & ~lane_mask) | (lane_data & lane_mask);
                state_d = WRITE;
            end
            WRITE: if (!mem_wait) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            half_q <= 1'b0;
            mis_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            buf_q <= '0;
        end else begin
            state_q <= state_d;
            half_q <= half_d;
            mis_q <= mis_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            buf_q <= buf_d;
        end
    end
    assign done = state_q == DONE;
    assign misaligned = done && mis_q;
    assign mem_ren = state_q == READ;
    assign mem_wen = state_q == WRITE;
    assign mem_addr = mem_ren || mem_wen ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_store = buf_q;
endmodule

// File: tb/tb_store_merger.sv
// tb_store_merger: randomized and directed checks of store_merger against a byte-lane memory model
module tb_store_merger;
    logic CLK = 1'b0;
    logic RST, req, mem_wait, done, misaligned, mem_ren, mem_wen;
    logic [1:0] size;
    logic [31:0] addr, wdata, mem_addr, mem_store, mem_load, last_rd;
    logic [31:0] mem [256];
    int vecs = 0, errs = 0;
    int wait_mode = 0, fixed_waits = 0, inj = 0, rd_cnt = 0, wr_cnt = 0, lat = 0;
    bit got_mis, both, bad_addr, unstable, stray;

    always #5 CLK = ~CLK;

    store_merger dut (
        .CLK(CLK), .RST(RST), .req(req), .size(size), .addr(addr), .wdata(wdata),
        .done(done), .misaligned(misaligned), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load), .mem_wait(mem_wait)
    );

    assign mem_load = mem[mem_addr[9:2]];

    initial forever begin
        @(posedge CLK);
        if (mem_ren && !mem_wait) begin last_rd = mem_load; rd_cnt++; end
        if (mem_wen && !mem_wait) begin mem[mem_addr[9:2]] = mem_store; wr_cnt++; end
    end

    initial begin
        int wcnt, prev, kind;
        wcnt = 0; prev = 0; mem_wait = 1'b0;
        forever begin
            @(negedge CLK);
            kind = mem_ren ? 1 : mem_wen ? 2 : 0;
            if (kind != prev) wcnt = 0;
            prev = kind;
            mem_wait = 1'b0;
            if (kind != 0 && wait_mode == 1 && wcnt < fixed_waits) begin mem_wait = 1'b1; wcnt++; end
            if (kind != 0 && wait_mode == 2 && $urandom_range(0, 2) == 0) mem_wait = 1'b1;
            if (mem_wait) inj++;
        end
    end

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = old[31 - 8 * i -: 8];
        if (sz == 2'b00) b[a[1:0]] = wd[7:0];
        else if (sz == 2'b01) begin b[{a[1], 1'b0}] = wd[15:8]; b[{a[1], 1'b1}] = wd[7:0]; end
        else for (int i = 0; i < 4; i++) b[i] = wd[31 - 8 * i -: 8];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input bit hold, input bit b2b);
        logic [31:0] last_st;
        bit prev_wen, got_done;
        last_st = '0; prev_wen = 0; got_done = 0;
        size = sz; addr = a; wdata = wd; req = 1'b1;
        inj = 0; lat = 0; got_mis = 0; both = 0; bad_addr = 0; unstable = 0; stray = 0;
        rd_cnt = 0; wr_cnt = 0;
        if (b2b) @(posedge CLK);
        @(posedge CLK);
        for (int n = 1; n <= 200 && !got_done; n++) begin
            @(negedge CLK);
            if (done) begin got_done = 1; lat = n; got_mis = misaligned; end
            if (misaligned && !done) stray = 1;
            if (mem_ren && mem_wen) both = 1;
            if ((mem_ren || mem_wen) && mem_addr !== {a[31:2], 2'b00}) bad_addr = 1;
            if (!(mem_ren || mem_wen) && mem_addr !== 32'h0) bad_addr = 1;
            if (mem_wen && prev_wen && mem_store !== last_st) unstable = 1;
            prev_wen = mem_wen; last_st = mem_store;
            if (!done) begin size = 2'($urandom); addr = $urandom; wdata = $urandom; end
        end
        if (!hold) begin req = 1'b0; @(negedge CLK); end
    endtask

    task automatic test_reset;
        RST = 1'b1; req = 1'b0; size = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vecs++; if ({done, misaligned, mem_ren, mem_wen} !== 4'b0) begin errs++; $display("FAIL reset_ctrl got %b want 0000", {done, misaligned, mem_ren, mem_wen}); end
        vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        vecs++; if (mem_store !== 32'h0) begin errs++; $display("FAIL reset_store got %h want 0", mem_store); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_byte;
        wait_mode = 0;
        mem[8'h40] = 32'h1122_3344;
        run_store(2'b00, 32'h0000_0102, 32'hFFFF_FFAB, 0, 0);
        vecs++; if (mem[8'h40] !== 32'h1122_AB44) begin errs++; $display("FAIL byte_data got %h want 1122ab44", mem[8'h40]); end
        vecs++; if (lat !== 3) begin errs++; $display("FAIL byte_lat got %0d want 3", lat); end
        vecs++; if (rd_cnt !== 1 || wr_cnt !== 1) begin errs++; $display("FAIL byte_access got rd=%0d wr=%0d want 1/1", rd_cnt, wr_cnt); end
        vecs++; if (bad_addr || both) begin errs++; $display("FAIL byte_addr got bad=%0d both=%0d want 0", bad_addr, both); end
    endtask

    task automatic test_half_wait;
        wait_mode = 1; fixed_waits = 2;
        mem[8'h80] = 32'hDEAD_BEEF;
        run_store(2'b01, 32'h0000_0200, 32'h0000_1234, 0, 0);
        vecs++; if (mem[8'h80] !== 32'h1234_BEEF) begin errs++; $display("FAIL half_data got %h want 1234beef", mem[8'h80]); end
        vecs++; if (lat !== 7) begin errs++; $display("FAIL half_lat got %0d want 7", lat); end
        vecs++; if (unstable) begin errs++; $display("FAIL half_store_stable got unstable=1 want 0"); end
        wait_mode = 0;
    endtask

    task automatic test_word;
        mem[8'h10] = 32'h5555_5555;
        run_store(2'b10, 32'h0000_0040, 32'hCAFE_F00D, 0, 0);
        vecs++; if (mem[8'h10] !== 32'hCAFE_F00D) begin errs++; $display("FAIL word_data got %h want cafef00d", mem[8'h10]); end
        vecs++; if (lat !== 2) begin errs++; $display("FAIL word_lat got %0d want 2", lat); end
        vecs++; if (rd_cnt !== 0 || wr_cnt !== 1) begin errs++; $display("FAIL word_access got rd=%0d wr=%0d want 0/1", rd_cnt, wr_cnt); end
    endtask

    task automatic test_misaligned;
        logic [1:0] sz [2];
        logic [31:0] a [2];
        sz[0] = 2'b01; a[0] = 32'h0000_0003;
        sz[1] = 2'b10; a[1] = 32'h0000_0002;
        mem[0] = 32'h0BAD_F00D;
        for (int i = 0; i < 2; i++) begin
            run_store(sz[i], a[i], 32'hFFFF_FFFF, 0, 0);
            vecs++; if (lat !== 1 || got_mis !== 1'b1) begin errs++; $display("FAIL mis%0d_done got lat=%0d mis=%0d want 1/1", i, lat, got_mis); end
            vecs++; if (rd_cnt !== 0 || wr_cnt !== 0 || mem[0] !== 32'h0BAD_F00D) begin errs++; $display("FAIL mis%0d_noaccess got rd=%0d wr=%0d mem=%h want 0/0/0badf00d", i, rd_cnt, wr_cnt, mem[0]); end
        end
    endtask

    task automatic test_back_to_back;
        mem[0] = 32'h0;
        run_store(2'b00, 32'h0000_0000, 32'h0000_00AA, 1, 0);
        vecs++; if (lat !== 3 || mem[0] !== 32'hAA00_0000) begin errs++; $display("FAIL b2b_first got lat=%0d mem=%h want 3/aa000000", lat, mem[0]); end
        run_store(2'b00, 32'h0000_0003, 32'h0000_00BB, 0, 1);
        vecs++; if (last_rd !== 32'hAA00_0000) begin errs++; $display("FAIL b2b_read got %h want aa000000", last_rd); end
        vecs++; if (mem[0] !== 32'hAA00_00BB) begin errs++; $display("FAIL b2b_final got %h want aa0000bb", mem[0]); end
        vecs++; if (lat !== 3) begin errs++; $display("FAIL b2b_lat got %0d want 3", lat); end
    endtask

    task automatic test_random;
        wait_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] sz;
            logic [31:0] a, wd, old, exp;
            bit mis;
            int base;
            sz = 2'($urandom); a = $urandom_range(0, 1023); wd = $urandom;
            old = $urandom; mem[a[9:2]] = old;
            mis = sz == 2'b01 ? a[0] : (sz[1] && a[1:0] != 2'b00);
            exp = mis ? old : ref_merge(old, sz, a, wd);
            base = mis ? 1 : sz[1] ? 2 : 3;
            run_store(sz, a, wd, 0, 0);
            vecs++; if (mem[a[9:2]] !== exp) begin errs++; $display("FAIL rnd%0d_data got %h want %h", i, mem[a[9:2]], exp); end
            vecs++; if (lat !== base + inj) begin errs++; $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, base + inj); end
            vecs++; if (got_mis !== mis) begin errs++; $display("FAIL rnd%0d_mis got %0d want %0d", i, got_mis, mis); end
            vecs++; if (rd_cnt !== ((mis || sz[1]) ? 0 : 1) || wr_cnt !== (mis ? 0 : 1)) begin errs++; $display("FAIL rnd%0d_access got rd=%0d wr=%0d", i, rd_cnt, wr_cnt); end
            vecs++; if (both || bad_addr || unstable || stray) begin errs++; $display("FAIL rnd%0d_proto got both=%0d addr=%0d unstable=%0d stray=%0d want 0", i, both, bad_addr, unstable, stray); end
        end
        wait_mode = 0;
    endtask

    task automatic test_reset_mid;
        int wr0;
        bit saw_done;
        saw_done = 0;
        wait_mode = 1; fixed_waits = 20;
        mem[8'h20] = 32'h1357_9BDF;
        size = 2'b10; addr = 32'h0000_0080; wdata = 32'h2468_ACE0; req = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        vecs++; if (mem_wen !== 1'b1) begin errs++; $display("FAIL rstmid_inwrite got wen=%b want 1", mem_wen); end
        req = 1'b0; RST = 1'b1; wr0 = wr_cnt;
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            vecs++; if ({done, misaligned, mem_ren, mem_wen} !== 4'b0 || mem_addr !== 32'h0 || mem_store !== 32'h0) begin errs++; $display("FAIL rstmid_out%0d got ctrl=%b addr=%h store=%h want 0", c, {done, misaligned, mem_ren, mem_wen}, mem_addr, mem_store); end
        end
        RST = 1'b0;
        repeat (4) begin @(negedge CLK); if (done || mem_ren || mem_wen) saw_done = 1; end
        vecs++; if (saw_done) begin errs++; $display("FAIL rstmid_quiet got activity=1 want 0"); end
        vecs++; if (wr_cnt !== wr0 || mem[8'h20] !== 32'h1357_9BDF) begin errs++; $display("FAIL rstmid_abandon got mem=%h want 13579bdf", mem[8'h20]); end
        wait_mode = 0; fixed_waits = 0;
        run_store(2'b00, 32'h0000_0081, 32'h0000_0077, 0, 0);
        vecs++; if (mem[8'h20] !== 32'h1377_9BDF || lat !== 3) begin errs++; $display("FAIL rstmid_recover got mem=%h lat=%0d want 13779bdf/3", mem[8'h20], lat); end
    endtask

    initial begin
        test_reset;
        test_byte;
        test_half_wait;
        test_word;
        test_misaligned;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
